memsplit_initiator: RTL and testbench

MEMSPLIT_INITIATOR -- requirements
Module: memsplit_initiator

---
 rtl/memsplit_initiator_if.sv | 48 ++++
 rtl/memsplit_initiator.sv | 163 ++++++++++++++++
 tb/tb_memsplit_initiator.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memsplit_initiator_if.sv
// ============================================================================
// Module      : memsplit_initiator_if
// Description : Command, response and MemSplit32 bus signals for the initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface memsplit_initiator_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_bi;
    logic [3:0]  cmd_be_bi;
    logic [31:0] cmd_wdata_bi;

    logic        rsp_valid_o;
    logic        rsp_we_o;
    logic        rsp_err_o;
    logic [31:0] rsp_rdata_bo;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_bo;
    logic [3:0]  bus_be_bo;
    logic [31:0] bus_wdata_bo;
    logic        bus_ack_i;
    logic        bus_resp_i;
    logic [31:0] bus_rdata_bi;

    // Initiator side.
    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_bi, cmd_be_bi, cmd_wdata_bi,
        input  bus_ack_i, bus_resp_i, bus_rdata_bi,
        output cmd_ready_o, rsp_valid_o, rsp_we_o, rsp_err_o, rsp_rdata_bo,
        output bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo
    );

    // Command producer plus bus slave side.
    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_bi, cmd_be_bi, cmd_wdata_bi,
        output bus_ack_i, bus_resp_i, bus_rdata_bi,
        input  cmd_ready_o, rsp_valid_o, rsp_we_o, rsp_err_o, rsp_rdata_bo,
        input  bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo
    );
endinterface

`default_nettype wire

// File: rtl/memsplit_initiator.sv
// ============================================================================
// Module      : memsplit_initiator
// Description : Buffered command FIFO feeding a single-beat MemSplit32 master.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module memsplit_initiator #(
    parameter int BUS_TIMEOUT    = 100,
    parameter int CMD_FIFO_DEPTH = 4
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    memsplit_initiator_if.master   ifc
);

    localparam int c_AW = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
    localparam int c_CW = $clog2(CMD_FIFO_DEPTH + 1);
    localparam int c_TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam int c_EW = 1 + 32 + 4 + 32;

    localparam logic [c_AW-1:0] c_PTR_LAST = c_AW'(CMD_FIFO_DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(CMD_FIFO_DEPTH);
    localparam logic [c_TW-1:0] c_TLIMIT   = c_TW'(BUS_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQ       = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    logic [c_EW-1:0] r_fifo_mem [CMD_FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic [1:0]      r_state;
    logic [c_TW-1:0] r_tcnt;
    logic            r_bus_we;
    logic [31:0]     r_bus_addr;
    logic [3:0]      r_bus_be;
    logic [31:0]     r_bus_wdata;
    logic            r_rsp_we;
    logic            r_rsp_err;
    logic [31:0]     r_rsp_rdata;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [c_EW-1:0] w_head;
    logic            w_limit;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_push  = ifc.cmd_valid_i && !w_full;
    assign w_pop   = (r_state == ST_IDLE) && (r_count != '0);
    assign w_head  = r_fifo_mem[r_rd_ptr];
    assign w_limit = (r_tcnt == c_TLIMIT);

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {ifc.cmd_we_i, ifc.cmd_addr_bi,
                                     ifc.cmd_be_bi, ifc.cmd_wdata_bi};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // An ack/resp seen on the limit cycle is checked first, so success wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_tcnt      <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_bus_we, r_bus_addr, r_bus_be, r_bus_wdata} <= w_head;
                        r_tcnt  <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_tcnt <= r_tcnt + c_TW'(1);
                    if (ifc.bus_ack_i) begin
                        if (r_bus_we) begin
                            r_rsp_we    <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= '0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT_RESP;
                        end
                    end else if (w_limit) begin
                        r_rsp_we    <= r_bus_we;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_WAIT_RESP: begin
                    r_tcnt <= r_tcnt + c_TW'(1);
                    if (ifc.bus_resp_i) begin
                        r_rsp_we    <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= ifc.bus_rdata_bi;
                        r_state     <= ST_DONE;
                    end else if (w_limit) begin
                        r_rsp_we    <= 1'b0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ifc.cmd_ready_o  = !w_full;
    assign ifc.bus_req_o    = (r_state == ST_REQ);
    assign ifc.bus_we_o     = r_bus_we;
    assign ifc.bus_addr_bo  = r_bus_addr;
    assign ifc.bus_be_bo    = r_bus_be;
    assign ifc.bus_wdata_bo = r_bus_wdata;
    assign ifc.rsp_valid_o  = (r_state == ST_DONE);
    assign ifc.rsp_we_o     = r_rsp_we;
    assign ifc.rsp_err_o    = r_rsp_err;
    assign ifc.rsp_rdata_bo = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_memsplit_initiator.sv
// ============================================================================
// Module      : tb_memsplit_initiator
// Description : Directed scenario bench for memsplit_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_memsplit_initiator;

    logic clk_i;
    logic rst_i;
    int   total;
    int   bad;

    memsplit_initiator_if u_if ();

    memsplit_initiator #(
        .BUS_TIMEOUT    (100),
        .CMD_FIFO_DEPTH (4)
    ) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ifc   (u_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
        u_if.cmd_valid_i  = 1'b1;
        u_if.cmd_we_i     = we;
        u_if.cmd_addr_bi  = addr;
        u_if.cmd_be_bi    = be;
        u_if.cmd_wdata_bi = wdata;
    endtask

    task automatic test_reset();
        logic [139:0] got;
        rst_i = 1'b1;
        step();
        step();
        got = {u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_bo, u_if.bus_be_bo,
               u_if.bus_wdata_bo, u_if.rsp_valid_o, u_if.rsp_we_o, u_if.rsp_err_o,
               u_if.rsp_rdata_bo, u_if.cmd_ready_o};
        total++;
        if (got !== 140'h1) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", got, 140'h1);
        end
        rst_i = 1'b0;
        step();
        total++;
        if (u_if.bus_req_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_req: got %b want 0", u_if.bus_req_o);
        end
    endtask

    task automatic test_write();
        push_cmd(1'b1, 32'h0, 4'hF, 32'h1234);
        step();                               // cycle 1
        u_if.cmd_valid_i = 1'b0;
        total++;
        if (u_if.bus_req_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_c1_req: got %b want 0", u_if.bus_req_o);
        end
        step();                               // cycle 2
        total++;
        if ({u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_bo, u_if.bus_be_bo,
             u_if.bus_wdata_bo} !== {1'b1, 1'b1, 32'h0, 4'hF, 32'h1234}) begin
            bad++;
            $display("FAIL wr_c2_beat: got req=%b we=%b addr=%h be=%h wd=%h want 1 1 0 f 1234",
                     u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_bo,
                     u_if.bus_be_bo, u_if.bus_wdata_bo);
        end
        u_if.bus_ack_i = 1'b1;
        step();                               // cycle 3
        u_if.bus_ack_i = 1'b0;
        total++;
        if ({u_if.bus_req_o, u_if.rsp_valid_o, u_if.rsp_we_o, u_if.rsp_err_o,
             u_if.rsp_rdata_bo} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL wr_c3_rsp: got req=%b v=%b we=%b err=%b rd=%h want 0 1 1 0 0",
                     u_if.bus_req_o, u_if.rsp_valid_o, u_if.rsp_we_o,
                     u_if.rsp_err_o, u_if.rsp_rdata_bo);
        end
        step();                               // cycle 4
        total++;
        if (u_if.rsp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_c4_pulse: got %b want 0", u_if.rsp_valid_o);
        end
    endtask

    task automatic test_read();
        push_cmd(1'b0, 32'h8000_0004, 4'hF, 32'h0);
        step();
        u_if.cmd_valid_i = 1'b0;
        step();                               // cycle 2
        total++;
        if ({u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_bo} !==
            {1'b1, 1'b0, 32'h8000_0004}) begin
            bad++;
            $display("FAIL rd_c2_beat: got req=%b we=%b addr=%h want 1 0 80000004",
                     u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_bo);
        end
        u_if.bus_ack_i = 1'b1;
        step();                               // cycle 3
        u_if.bus_ack_i = 1'b0;
        total++;
        if ({u_if.bus_req_o, u_if.rsp_valid_o} !== 2'b00) begin
            bad++;
            $display("FAIL rd_c3_wait: got req=%b v=%b want 0 0",
                     u_if.bus_req_o, u_if.rsp_valid_o);
        end
        u_if.bus_resp_i   = 1'b1;
        u_if.bus_rdata_bi = 32'hDEAD_BEEF;
        step();                               // cycle 4
        u_if.bus_resp_i   = 1'b0;
        u_if.bus_rdata_bi = 32'h0;
        total++;
        if ({u_if.rsp_valid_o, u_if.rsp_we_o, u_if.rsp_err_o, u_if.rsp_rdata_bo} !==
            {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL rd_c4_rsp: got v=%b we=%b err=%b rd=%h want 1 0 0 deadbeef",
                     u_if.rsp_valid_o, u_if.rsp_we_o, u_if.rsp_err_o, u_if.rsp_rdata_bo);
        end
        step();
    endtask

    task automatic test_stall();
        push_cmd(1'b0, 32'h0000_0100, 4'h3, 32'h0);
        step();
        u_if.cmd_valid_i = 1'b0;
        step();                               // cycle 2
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_bo, u_if.bus_be_bo} !==
                {1'b1, 1'b0, 32'h100, 4'h3}) begin
                bad++;
                $display("FAIL stall_hold%0d: got req=%b we=%b addr=%h be=%h want 1 0 100 3",
                         i, u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_bo, u_if.bus_be_bo);
            end
            if (i < 3) begin
                u_if.bus_resp_i = 1'b1;       // stray resp during REQ must be ignored
                step();
            end
        end
        u_if.bus_resp_i = 1'b0;
        u_if.bus_ack_i  = 1'b1;
        step();                               // cycle 6
        u_if.bus_ack_i = 1'b0;
        total++;
        if ({u_if.bus_req_o, u_if.rsp_valid_o} !== 2'b00) begin
            bad++;
            $display("FAIL stall_wait: got req=%b v=%b want 0 0",
                     u_if.bus_req_o, u_if.rsp_valid_o);
        end
        u_if.bus_resp_i   = 1'b1;
        u_if.bus_rdata_bi = 32'hCAFE_0001;
        step();                               // cycle 7
        u_if.bus_resp_i   = 1'b0;
        u_if.bus_rdata_bi = 32'h0;
        total++;
        if ({u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_rdata_bo} !==
            {1'b1, 1'b0, 32'hCAFE_0001}) begin
            bad++;
            $display("FAIL stall_rsp: got v=%b err=%b rd=%h want 1 0 cafe0001",
                     u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_rdata_bo);
        end
        step();
    endtask

    // with_resp=1 delivers the response on the limit cycle (cycle 101).
    task automatic test_timeout(input logic with_resp);
        int early;
        early = 0;
        push_cmd(1'b0, 32'h0000_0200, 4'hF, 32'h0);
        step();
        u_if.cmd_valid_i = 1'b0;
        step();                               // cycle 2: REQ entry
        u_if.bus_ack_i = 1'b1;
        step();                               // cycle 3
        u_if.bus_ack_i = 1'b0;
        for (int c = 3; c < 102; c++) begin
            if (u_if.rsp_valid_o) early++;
            if (with_resp && c == 101) begin
                u_if.bus_resp_i   = 1'b1;
                u_if.bus_rdata_bi = 32'h5A5A_5A5A;
            end
            step();
        end
        u_if.bus_resp_i   = 1'b0;
        u_if.bus_rdata_bi = 32'h0;
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL to_early%0b: got %0d early pulses want 0", with_resp, early);
        end
        total++;
        if (with_resp) begin
            if ({u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_rdata_bo} !==
                {1'b1, 1'b0, 32'h5A5A_5A5A}) begin
                bad++;
                $display("FAIL to_edge_win: got v=%b err=%b rd=%h want 1 0 5a5a5a5a",
                         u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_rdata_bo);
            end
        end else begin
            if ({u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_rdata_bo} !==
                {1'b1, 1'b1, 32'h0}) begin
                bad++;
                $display("FAIL to_err: got v=%b err=%b rd=%h want 1 1 0",
                         u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_rdata_bo);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int w;
        int stray;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (u_if.cmd_ready_o !== (i < 5)) begin
                bad++;
                $display("FAIL b2b_ready%0d: got %b want %b", i, u_if.cmd_ready_o, (i < 5));
            end
            push_cmd(1'b1, 32'(16 * (i + 1)), 4'hF, 32'(i));
            step();
        end
        u_if.cmd_valid_i = 1'b0;
        total++;
        if ({u_if.cmd_ready_o, u_if.bus_req_o, u_if.bus_addr_bo} !== {1'b0, 1'b1, 32'h10}) begin
            bad++;
            $display("FAIL b2b_full: got ready=%b req=%b addr=%h want 0 1 10",
                     u_if.cmd_ready_o, u_if.bus_req_o, u_if.bus_addr_bo);
        end
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!u_if.bus_req_o && w < 8) begin
                step();
                w++;
            end
            total++;
            if ({u_if.bus_req_o, u_if.bus_addr_bo, u_if.bus_wdata_bo} !==
                {1'b1, 32'(16 * (k + 1)), 32'(k)}) begin
                bad++;
                $display("FAIL b2b_order%0d: got req=%b addr=%h wd=%h want 1 %h %h",
                         k, u_if.bus_req_o, u_if.bus_addr_bo, u_if.bus_wdata_bo,
                         32'(16 * (k + 1)), 32'(k));
            end
            u_if.bus_ack_i = 1'b1;
            step();
            u_if.bus_ack_i = 1'b0;
            total++;
            if ({u_if.rsp_valid_o, u_if.rsp_we_o, u_if.rsp_err_o} !== 3'b110) begin
                bad++;
                $display("FAIL b2b_rsp%0d: got v=%b we=%b err=%b want 1 1 0",
                         k, u_if.rsp_valid_o, u_if.rsp_we_o, u_if.rsp_err_o);
            end
        end
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            if (u_if.bus_req_o) stray++;
            step();
        end
        total++;
        if (stray !== 0 || u_if.cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_dropped: got %0d stray req cycles ready=%b want 0 1",
                     stray, u_if.cmd_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [139:0] got;
        int stray;
        push_cmd(1'b0, 32'h300, 4'hF, 32'h0);
        step();
        push_cmd(1'b0, 32'h304, 4'hF, 32'h0);
        step();                               // cycle 2
        push_cmd(1'b0, 32'h308, 4'hF, 32'h0);
        u_if.bus_ack_i = 1'b1;
        step();                               // cycle 3: WAIT_RESP, 2 queued
        u_if.bus_ack_i   = 1'b0;
        u_if.cmd_valid_i = 1'b0;
        rst_i = 1'b1;
        step();                               // cycle 4
        rst_i = 1'b0;
        got = {u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_bo, u_if.bus_be_bo,
               u_if.bus_wdata_bo, u_if.rsp_valid_o, u_if.rsp_we_o, u_if.rsp_err_o,
               u_if.rsp_rdata_bo, u_if.cmd_ready_o};
        total++;
        if (got !== 140'h1) begin
            bad++;
            $display("FAIL rstmid_outputs: got %h want %h", got, 140'h1);
        end
        u_if.bus_resp_i   = 1'b1;
        u_if.bus_rdata_bi = 32'hFFFF_FFFF;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            u_if.bus_resp_i = 1'b0;
            if (u_if.bus_req_o || u_if.rsp_valid_o) stray++;
        end
        u_if.bus_rdata_bi = 32'h0;
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", stray);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_i = 1'b1;
        u_if.cmd_valid_i  = 1'b0;
        u_if.cmd_we_i     = 1'b0;
        u_if.cmd_addr_bi  = 32'h0;
        u_if.cmd_be_bi    = 4'h0;
        u_if.cmd_wdata_bi = 32'h0;
        u_if.bus_ack_i    = 1'b0;
        u_if.bus_resp_i   = 1'b0;
        u_if.bus_rdata_bi = 32'h0;

        test_reset();
        test_write();
        test_read();
        test_stall();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
